// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and baud divider helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Rounded clocks-per-tick, never below 1.
  function automatic int baud_div(input int clk, input int baud, input int os);
    int d;
    d = (clk + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, restartable.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= '0;
    else if (clear)                cnt <= '0;
    else if (cnt == W'(DIV - 1))   cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with sync, false-start rejection, 3-sample majority
// vote per bit, optional parity and one-cycle valid/frame_err/parity_err pulses.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  busy
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_WIDTH + 1);

  logic                  rx_s1, rx_s2, rx_d;
  logic                  start_edge, clear, tick, vote, at_vote, at_end, done;
  logic [SW-1:0]         s;
  logic [BW-1:0]         bitcnt;
  logic [1:0]            smp;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bad;
  rx_state_t             state, state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Only a real 1->0 transition starts a frame, so a held break never retriggers.
  assign start_edge = rx_d & ~rx_s2;
  assign clear      = (state == ST_IDLE) && start_edge;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // Third sample is the live synchronised line at s = M+1.
  assign vote    = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);
  assign at_vote = tick && (s == SW'(M + 1));
  assign at_end  = tick && (s == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_edge) state_nxt = ST_START;
      ST_START:  if (at_vote && vote) state_nxt = ST_IDLE;
                 else if (at_end)     state_nxt = ST_DATA;
      ST_DATA:   if (at_end && bitcnt == BW'(DATA_WIDTH - 1))
                   state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (at_end) state_nxt = ST_STOP;
      ST_STOP:   if (at_vote) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_STOP) && at_vote;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s          <= '0;
      bitcnt     <= '0;
      smp        <= 2'b11;
      shreg      <= '0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (clear) begin
        s       <= '0;
        bitcnt  <= '0;
        par_bad <= 1'b0;
      end else if (tick && busy) begin
        s <= (s == SW'(OVERSAMPLE - 1)) ? '0 : s + 1'b1;
        if (s == SW'(M - 1)) smp[0] <= rx_s2;
        if (s == SW'(M))     smp[1] <= rx_s2;
        if (state == ST_DATA && at_vote) shreg  <= {vote, shreg[DATA_WIDTH-1:1]};
        if (state == ST_DATA && at_end)  bitcnt <= bitcnt + 1'b1;
        // Odd mode wants the total XOR to be 1, even mode 0.
        if (state == ST_PARITY && at_vote)
          par_bad <= (^{shreg, vote}) ^ (PARITY == PAR_ODD);
      end
      if (done) begin
        if (!vote)        frame_err  <= 1'b1;
        else if (par_bad) parity_err <= 1'b1;
        else begin
          valid    <= 1'b1;
          data_out <= shreg;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver that turns the asynchronous `rx` pin into byte-wide words with a one-cycle `valid` strobe. It sits directly upstream of the block buffer and UART transmitter, which consume `data_out`/`valid` unchanged. The block adds input synchronisation, glitch rejection, majority-vote bit sampling, optional parity, and framing/parity error reporting.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line bit rate
- `OVERSAMPLE`, 16, ticks per bit; even, ≥8
- `DATA_WIDTH`, 8, data bits per frame, 5..9
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `rx`  in  1  asynchronous serial line, idle high
- `data_out`  out  DATA_WIDTH  last good word, LSB = first received bit
- `valid`  out  1  one-cycle pulse; `data_out` updated in the same cycle
- `frame_err`  out  1  one-cycle pulse; stop bit sampled 0
- `parity_err`  out  1  one-cycle pulse; parity mismatch with a good stop bit
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- `rx` passes through a 2-FF synchroniser (both FFs reset to 1), then a 1-FF edge register.
- Tick divider `DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE)` (rounded, minimum 1).
  - The divider is cleared on start detection.
  - It produces one tick every DIV clocks.
- Sample counter `s` runs 0..OVERSAMPLE-1 per bit and advances on each tick. Let `M = OVERSAMPLE/2`.
- Each bit takes samples at `s = M-1, M, M+1`. The bit value is the majority of those 3 samples.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** a synchronised 1→0 transition clears the divider, sets `s=0`, and moves to START. A line held low (break) never retriggers.
  - **START:** if the voted bit is 1 at `s=M+1`, the start is false: go to IDLE with no pulse. At `s=OVERSAMPLE-1`, go to DATA.
  - **DATA:** shift in DATA_WIDTH bits, LSB first. The bit counter is `$clog2(DATA_WIDTH+1)` wide. After the last bit, go to PARITY if `PARITY!=0`, otherwise go to STOP.
  - **PARITY:** compute the XOR of the data bits and the parity bit; odd mode expects 1, even mode expects 0. The result is held until STOP.
  - **STOP:** evaluate the vote at `s=M+1`, then return to IDLE immediately, without waiting for the end of the stop bit. This gives half a bit of slack for back-to-back frames.
- Outcome, exactly one pulse per completed frame:
  - stop=0 → `frame_err`. This takes priority over parity.
  - Otherwise, parity bad → `parity_err`.
  - Otherwise → `valid`, and `data_out` loads the shift register.
- On either error, `data_out` keeps its previous value.
- No backpressure: downstream must accept every `valid`. Frames are never stalled.

## Timing
- Reset values: `data_out=0`, `valid=0`, `frame_err=0`, `parity_err=0`, `busy=0`. The FSM is in IDLE and the synchroniser is at 1.
- Reset is asynchronous mid-frame: everything returns to reset values immediately, and the partial frame is dropped without a pulse.
- Start detect occurs 3 clocks after the `rx` pin edge (2 synchroniser clocks plus 1 edge-register clock). `busy` rises in the cycle after detect.
- Outcome pulse timing:
  - Let `N = 1 + DATA_WIDTH + (PARITY!=0)`.
  - The pulse occurs `(N*OVERSAMPLE + M+2)*DIV` clocks after detect, ±2 clocks.
  - The pulse lasts exactly 1 cycle.
  - `busy` falls in the same cycle as the pulse.
- A new start edge is accepted in the cycle after the STOP → IDLE transition.
- Tolerance: correct reception for baud mismatch up to ±3% at OVERSAMPLE=16.

## Structure
- Shared package `uart_pkg`:
  - Parity mode constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`).
  - FSM state encoding.
  - Function `baud_div(clk, baud, os)` returning the rounded DIV.
- Sub-module `uart_baud_tick`:
  - Parameter `DIV`.
  - Inputs `clk`, `rst_n`, `clear`; output `tick`.
  - `tick` is a one-cycle pulse every DIV clocks; `clear` restarts the count at 0.

## Test plan
Use `CLK_FREQ=1_600_000`, `BAUD=10_000`, `OVERSAMPLE=16`, giving `DIV=10` (160 clocks/bit).
- Frame 0xA5, 8N1 → one `valid`, `data_out=0xA5`, no error pulses, `busy` low afterwards.
- 30-clock low glitch on idle `rx` → `busy` pulses, START aborts, no `valid`/`frame_err`; a following 0x3C is received correctly.
- Frame 0x55 with stop bit forced 0 → one `frame_err`, no `valid`, `data_out` keeps 0x3C. A held-low break produces no further pulses until `rx` returns high.
- `PARITY=2`, frame 0x07 with parity bit 0 (wrong) → `parity_err`. Resent with parity 1 → `valid`, `data_out=0x07`.
- Back-to-back 0x00 then 0xFF with exactly one stop bit, sender 3% fast → two `valid` pulses with correct data.
- `rst_n` asserted for 5 clocks in the middle of DATA → all outputs 0 immediately, no pulse. The next frame 0x81 → `valid`, `data_out=0x81`.
